// File: rtl/writeback_buffer.sv
// Writeback buffer: queues ALU/LSU results in order, drains one per cycle into
// the register file write port and forwards pending values to two read ports.
module writeback_buffer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_CNT = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [AW-1:0]            lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic [AW-1:0]            a3,
  output logic [XLEN-1:0]          di3,
  output logic                     we3,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [XLEN-1:0]          fwd1_data,
  output logic [XLEN-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Reject parameter sets the pointer arithmetic cannot support
  if ((AW != $clog2(REG_CNT)) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("writeback_buffer: invalid parameter set");
  end

  logic [AW-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   free_c;
  logic            lsu_push_c;
  logic            alu_push_c;
  logic            pop_c;
  logic [PW-1:0]   alu_slot_c;
  logic            fwd1_hit_c;
  logic            fwd2_hit_c;
  logic [XLEN-1:0] fwd1_data_c;
  logic [XLEN-1:0] fwd2_data_c;

  // Youngest-wins search: FIFO head..tail-1, then LSU, then ALU accepted this edge
  function automatic logic [XLEN:0] lookup(input logic [AW-1:0] ra);
    logic            hit;
    logic [XLEN-1:0] val;
    logic [PW-1:0]   idx;
    hit = 1'b0;
    val = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (rd_q[idx] == ra)) begin
        hit = 1'b1;
        val = data_q[idx];
      end
    end
    if (lsu_push_c && (lsu_rd == ra)) begin
      hit = 1'b1;
      val = lsu_data;
    end
    if (alu_push_c && (alu_rd == ra)) begin
      hit = 1'b1;
      val = alu_data;
    end
    if (ra == '0) begin
      hit = 1'b0;
      val = '0;
    end
    return {hit, val};
  endfunction

  // Ready depends only on occupancy and lsu_valid, never on the drain
  always_comb begin
    free_c     = CW'(DEPTH) - count;
    lsu_ready  = (free_c >= CW'(1));
    alu_ready  = (free_c >= (CW'(1) + CW'(lsu_valid)));
    lsu_push_c = lsu_valid && lsu_ready && (lsu_rd != '0);
    alu_push_c = alu_valid && alu_ready && (alu_rd != '0);
    alu_slot_c = wr_ptr + PW'(lsu_push_c);
    empty      = (count == '0);
    pop_c      = !empty;
    a3         = rd_q[rd_ptr];
    di3        = data_q[rd_ptr];
    we3        = rst_n && pop_c;
  end

  // Forwarding candidates for both read ports
  always_comb begin
    {fwd1_hit_c, fwd1_data_c} = lookup(ra1);
    {fwd2_hit_c, fwd2_data_c} = lookup(ra2);
  end

  // Entry storage; LSU entry is written ahead of the ALU entry
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (lsu_push_c) begin
        rd_q[wr_ptr]   <= lsu_rd;
        data_q[wr_ptr] <= lsu_data;
      end
      if (alu_push_c) begin
        rd_q[alu_slot_c]   <= alu_rd;
        data_q[alu_slot_c] <= alu_data;
      end
    end
  end

  // Pointers, occupancy and registered forwarding results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fwd1_hit  <= 1'b0;
      fwd2_hit  <= 1'b0;
      fwd1_data <= '0;
      fwd2_data <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(lsu_push_c) + PW'(alu_push_c);
      rd_ptr    <= rd_ptr + PW'(pop_c);
      count     <= count - CW'(pop_c) + CW'(lsu_push_c) + CW'(alu_push_c);
      fwd1_hit  <= fwd1_hit_c;
      fwd2_hit  <= fwd2_hit_c;
      fwd1_data <= fwd1_data_c;
      fwd2_data <= fwd2_data_c;
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: main instance DEPTH=4, second DEPTH=2 for full-buffer behaviour.
module tb_writeback_buffer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            lsu_valid, lsu_ready, alu_valid, alu_ready;
  logic [AW-1:0]   lsu_rd, alu_rd, a3, ra1, ra2;
  logic [XLEN-1:0] lsu_data, alu_data, di3, fwd1_data, fwd2_data;
  logic            we3, fwd1_hit, fwd2_hit, empty;
  logic [2:0]      count;

  logic            b_lsu_valid, b_lsu_ready, b_alu_valid, b_alu_ready;
  logic [AW-1:0]   b_lsu_rd, b_alu_rd, b_a3, b_ra1, b_ra2;
  logic [XLEN-1:0] b_lsu_data, b_alu_data, b_di3, b_fwd1_data, b_fwd2_data;
  logic            b_we3, b_fwd1_hit, b_fwd2_hit, b_empty;
  logic [1:0]      b_count;

  writeback_buffer #(.XLEN(32), .REG_CNT(32), .AW(5), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .a3(a3), .di3(di3), .we3(we3), .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty)
  );

  writeback_buffer #(.XLEN(32), .REG_CNT(32), .AW(5), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(b_lsu_valid), .lsu_ready(b_lsu_ready), .lsu_rd(b_lsu_rd), .lsu_data(b_lsu_data),
    .alu_valid(b_alu_valid), .alu_ready(b_alu_ready), .alu_rd(b_alu_rd), .alu_data(b_alu_data),
    .a3(b_a3), .di3(b_di3), .we3(b_we3), .ra1(b_ra1), .ra2(b_ra2),
    .fwd1_hit(b_fwd1_hit), .fwd2_hit(b_fwd2_hit), .fwd1_data(b_fwd1_data), .fwd2_data(b_fwd2_data),
    .count(b_count), .empty(b_empty)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Register file write log of the main instance, sampled mid-cycle
  logic [AW+XLEN-1:0] wlog[$];
  always @(negedge clk) if (we3) wlog.push_back({a3, di3});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [AW+XLEN-1:0] expq[$];
    logic [AW+XLEN-1:0] ent;
    int  exp_count;
    int  id;
    int  n_wr;
    bit  e_lr, e_ar;

    rst_n = 1'b0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ra1 = '0; ra2 = '0;
    b_lsu_valid = 1'b0; b_lsu_rd = '0; b_lsu_data = '0;
    b_alu_valid = 1'b0; b_alu_rd = '0; b_alu_data = '0;
    b_ra1 = '0; b_ra2 = '0;

    // Reset then idle
    tick(); tick();
    chk("we3_in_reset", 32'(we3), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_we3", 32'(we3), 32'd0);
    chk("idle_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("idle_alu_ready", 32'(alu_ready), 32'd1);
    chk("idle_fwd1_hit", 32'(fwd1_hit), 32'd0);
    chk("idle_fwd2_hit", 32'(fwd2_hit), 32'd0);

    // Single ALU push rd=5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; ra1 = 5'd5;
    #1;
    chk("single_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("single_a3", 32'(a3), 32'd5);
    chk("single_di3", di3, 32'hDEADBEEF);
    chk("single_we3", 32'(we3), 32'd1);
    chk("single_fwd_push_hit", 32'(fwd1_hit), 32'd1);
    chk("single_fwd_push_data", fwd1_data, 32'hDEADBEEF);
    tick();
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_we3_off", 32'(we3), 32'd0);
    chk("single_fwd_drain_hit", 32'(fwd1_hit), 32'd1);
    chk("single_fwd_drain_data", fwd1_data, 32'hDEADBEEF);
    tick();
    chk("single_fwd_after_hit", 32'(fwd1_hit), 32'd0);
    chk("single_fwd_after_data", fwd1_data, 32'd0);

    // Simultaneous LSU and ALU to rd=3
    wlog.delete();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
    ra1 = 5'd3;
    #1;
    chk("dual_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0; alu_valid = 1'b0;
    #1;
    chk("dual_count2", 32'(count), 32'd2);
    chk("dual_fwd_hit0", 32'(fwd1_hit), 32'd1);
    chk("dual_fwd_data0", fwd1_data, 32'h22);
    tick();
    chk("dual_count1", 32'(count), 32'd1);
    chk("dual_fwd_data1", fwd1_data, 32'h22);
    tick();
    chk("dual_empty", 32'(empty), 32'd1);
    chk("dual_fwd_hit2", 32'(fwd1_hit), 32'd1);
    chk("dual_fwd_data2", fwd1_data, 32'h22);
    tick();
    chk("dual_fwd_hit3", 32'(fwd1_hit), 32'd0);
    chk("dual_wlog_size", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      ent = wlog[0];
      chk("dual_w0_rd", 32'(ent[AW+XLEN-1:XLEN]), 32'd3);
      chk("dual_w0_data", ent[XLEN-1:0], 32'h11);
      ent = wlog[1];
      chk("dual_w1_rd", 32'(ent[AW+XLEN-1:XLEN]), 32'd3);
      chk("dual_w1_data", ent[XLEN-1:0], 32'h22);
    end

    // Push to x0
    wlog.delete();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF; ra1 = 5'd0;
    #1;
    chk("x0_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("x0_count", 32'(count), 32'd0);
    chk("x0_we3", 32'(we3), 32'd0);
    chk("x0_fwd1_hit", 32'(fwd1_hit), 32'd0);
    tick();
    chk("x0_no_write", 32'(wlog.size()), 32'd0);

    // DEPTH=2 instance: fill to full, then partial readiness
    b_lsu_valid = 1'b1; b_lsu_rd = 5'd7; b_lsu_data = 32'h70;
    b_alu_valid = 1'b1; b_alu_rd = 5'd8; b_alu_data = 32'h80;
    #1;
    chk("d2_lsu_ready0", 32'(b_lsu_ready), 32'd1);
    chk("d2_alu_ready0", 32'(b_alu_ready), 32'd1);
    tick();
    b_lsu_rd = 5'd9; b_lsu_data = 32'h90;
    #1;
    chk("d2_full_count", 32'(b_count), 32'd2);
    chk("d2_full_lsu_ready", 32'(b_lsu_ready), 32'd0);
    chk("d2_full_alu_ready", 32'(b_alu_ready), 32'd0);
    chk("d2_head_a3", 32'(b_a3), 32'd7);
    chk("d2_head_di3", b_di3, 32'h70);
    tick();
    chk("d2_count1", 32'(b_count), 32'd1);
    chk("d2_lsu_ready1", 32'(b_lsu_ready), 32'd1);
    chk("d2_alu_ready1", 32'(b_alu_ready), 32'd0);
    chk("d2_head2_a3", 32'(b_a3), 32'd8);
    tick();
    b_lsu_valid = 1'b0; b_alu_valid = 1'b0;
    #1;
    chk("d2_wrap_count", 32'(b_count), 32'd1);
    chk("d2_wrap_a3", 32'(b_a3), 32'd9);
    chk("d2_wrap_di3", b_di3, 32'h90);
    tick();
    chk("d2_empty", 32'(b_empty), 32'd1);

    // Main instance: both producers push every cycle across pointer wrap
    wlog.delete();
    exp_count = 0; id = 0; n_wr = 0;
    for (int c = 0; c < 6; c++) begin
      lsu_valid = 1'b1; lsu_rd = AW'(id + 1); lsu_data = 32'hA0000000 + 32'(id);
      alu_valid = 1'b1; alu_rd = AW'(id + 2); alu_data = 32'hA0000000 + 32'(id + 1);
      #1;
      e_lr = (exp_count < 4);
      e_ar = ((4 - exp_count) >= 2);
      chk("fill_count", 32'(count), 32'(exp_count));
      chk("fill_lsu_ready", 32'(lsu_ready), 32'(e_lr));
      chk("fill_alu_ready", 32'(alu_ready), 32'(e_ar));
      if (exp_count != 0) n_wr++;
      if (e_lr) begin expq.push_back({lsu_rd, lsu_data}); id++; end
      if (e_ar) begin expq.push_back({alu_rd, alu_data}); id++; end
      exp_count = exp_count - ((exp_count != 0) ? 1 : 0) + int'(e_lr) + int'(e_ar);
      tick();
    end

    // Reset with three entries queued and both producers pushing
    lsu_rd = 5'd30; lsu_data = 32'hBAD00001;
    alu_rd = 5'd31; alu_data = 32'hBAD00002;
    ent = expq[expq.size() - 1];
    ra1 = ent[AW+XLEN-1:XLEN];
    ra2 = 5'd30;
    #1;
    chk("pre_reset_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("reset_we3_forced", 32'(we3), 32'd0);
    tick();
    rst_n = 1'b1; lsu_valid = 1'b0; alu_valid = 1'b0;
    #1;
    chk("post_reset_count", 32'(count), 32'd0);
    chk("post_reset_empty", 32'(empty), 32'd1);
    chk("post_reset_we3", 32'(we3), 32'd0);
    chk("post_reset_fwd1_hit", 32'(fwd1_hit), 32'd0);
    chk("post_reset_fwd2_hit", 32'(fwd2_hit), 32'd0);
    chk("post_reset_fwd1_data", fwd1_data, 32'd0);
    tick(); tick(); tick();
    chk("fill_wlog_size", 32'(wlog.size()), 32'(n_wr));
    for (int i = 0; i < n_wr; i++) begin
      if (i < wlog.size()) begin
        chk("fill_order", wlog[i][XLEN-1:0], expq[i][XLEN-1:0]);
        chk("fill_order_rd", 32'(wlog[i][AW+XLEN-1:XLEN]), 32'(expq[i][AW+XLEN-1:XLEN]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
